vga_sym_mem_arbiter: RTL and testbench

//  Shares the single-port text/symbol memory between the VGA display fetch path, a host/debug

---
 rtl/vga_arb_pkg.sv | 22 ++
 rtl/vga_arb_rd_pipe.sv | 38 +++
 rtl/vga_sym_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_sym_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared types and defaults for the symbol memory arbiter
package vga_arb_pkg;

  // Who owns the memory port in a given cycle; travels with reads to route returned data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2,
    OWN_CLR  = 2'd3
  } owner_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_t;

  // 80 columns x 35 rows of symbol codes.
  localparam int         DEF_MEM_DEPTH = 2800;
  // Blank (space) character written by the screen-clear engine.
  localparam logic [7:0] DEF_CLR_CHAR  = 8'h20;

endpackage

// File: rtl/vga_arb_rd_pipe.sv
// rtl/vga_arb_rd_pipe.sv - owner tag and out-of-range delay line matching memory read latency
module vga_arb_rd_pipe
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   resetn,
  input  owner_t in_owner,
  input  logic   in_oor,
  output owner_t out_owner,
  output logic   out_oor
);

  owner_t owner_q [DEPTH];
  logic   oor_q   [DEPTH];

  // Shift the grant tag along so it lines up with mem_rdata DEPTH cycles later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= OWN_NONE;
        oor_q[i]   <= 1'b0;
      end
    end else begin
      owner_q[0] <= in_owner;
      oor_q[0]   <= in_oor;
      for (int i = 1; i < DEPTH; i++) begin
        owner_q[i] <= owner_q[i-1];
        oor_q[i]   <= oor_q[i-1];
      end
    end
  end

  assign out_owner = owner_q[DEPTH-1];
  assign out_oor   = oor_q[DEPTH-1];

endmodule

// File: rtl/vga_sym_mem_arbiter.sv
// rtl/vga_sym_mem_arbiter.sv - symbol memory arbiter for display fetch, clear engine and host
module vga_sym_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int                ADDR_W    = 14,
  parameter int                DATA_W    = 8,
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLR_CHAR  = DATA_W'(DEF_CLR_CHAR)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  owner_t            grant_owner;
  logic              grant_oor;
  owner_t            tap_owner;
  logic              tap_oor;
  logic              disp_oor;
  logic              host_oor;
  logic              host_grant;
  logic              clr_wr;

  assign disp_oor   = (disp_addr >= DEPTH_A);
  assign host_oor   = (host_addr >= DEPTH_A);
  // Host only gets the port when the display is quiet and no clear sweep is running.
  assign host_grant = host_req && !disp_req && (state_q == ARB_IDLE);
  assign clr_wr     = (state_q == ARB_CLEAR) && !disp_req;
  assign host_ack   = host_grant;
  assign clr_busy   = (state_q == ARB_CLEAR);

  // Fixed-priority port mux: display, then clear write, then host; out-of-range never touches memory.
  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    grant_owner = OWN_NONE;
    grant_oor   = 1'b0;
    if (disp_req) begin
      grant_owner = OWN_DISP;
      grant_oor   = disp_oor;
      if (!disp_oor) begin
        mem_addr = disp_addr;
      end
    end else if (clr_wr) begin
      grant_owner = OWN_CLR;
      mem_addr    = clr_addr_q;
      mem_we      = 1'b1;
      mem_wdata   = CLR_CHAR;
    end else if (host_grant) begin
      grant_oor = host_oor;
      if (!host_we) begin
        grant_owner = OWN_HOST;
      end
      if (!host_oor) begin
        mem_addr  = host_addr;
        mem_we    = host_we;
        mem_wdata = host_we ? host_wdata : '0;
      end
    end
  end

  // Clear sweep: one location per free cycle, single pass, restarts ignored while running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB_IDLE;
      clr_addr_q <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (clr_start) begin
        state_q <= ARB_CLEAR;
      end
    end else if (clr_wr) begin
      if (clr_addr_q == LAST_A) begin
        clr_addr_q <= '0;
        state_q    <= ARB_IDLE;
      end else begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
      end
    end
  end

  vga_arb_rd_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_owner  (grant_owner),
    .in_oor    (grant_oor),
    .out_owner (tap_owner),
    .out_oor   (tap_oor)
  );

  // Route returning read data to its requester; out-of-range reads return zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_data   <= '0;
      disp_valid  <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      disp_valid  <= (tap_owner == OWN_DISP);
      host_rvalid <= (tap_owner == OWN_HOST);
      if (tap_owner == OWN_DISP) begin
        disp_data <= tap_oor ? '0 : mem_rdata;
      end
      if (tap_owner == OWN_HOST) begin
        host_rdata <= tap_oor ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_sym_mem_arbiter.sv
// tb/tb_vga_sym_mem_arbiter.sv - directed self-checking bench for vga_sym_mem_arbiter
module tb_vga_sym_mem_arbiter;

  localparam int DEPTH = 2800;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        disp_req = 1'b0;
  logic [13:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [13:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic [7:0]  mem [0:16383];

  int errors = 0;
  int checks = 0;
  int oor_writes = 0;

  vga_sym_mem_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (resetn && mem_we && (int'(mem_addr) >= DEPTH)) oor_writes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt, last_busy, disp_in_busy, wr_cnt, ack_idx, exp_ack, bad_lo, bad_hi, found;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) step();
    #1;
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    resetn = 1'b1;
    step();

    // 1: host write then read back
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'd5; host_wdata = 8'h41; #1;
    check("t1_wr_ack", 32'(host_ack), 32'd1);
    check("t1_wr_we", 32'(mem_we), 32'd1);
    check("t1_wr_addr", 32'(mem_addr), 32'd5);
    step();
    host_we = 1'b0; #1;
    check("t1_rd_ack", 32'(host_ack), 32'd1);
    check("t1_rd_we", 32'(mem_we), 32'd0);
    step();
    host_req = 1'b0;
    check("t1_rvalid_early", 32'(host_rvalid), 32'd0);
    step();
    check("t1_rvalid", 32'(host_rvalid), 32'd1);
    check("t1_rdata", 32'(host_rdata), 32'h41);
    step();
    check("t1_rvalid_pulse", 32'(host_rvalid), 32'd0);

    // 2: display and host collide
    mem[7] = 8'h77; mem[9] = 8'h99;
    disp_req = 1'b1; disp_addr = 14'd9; host_req = 1'b1; host_we = 1'b0; host_addr = 14'd7; #1;
    check("t2_host_blocked", 32'(host_ack), 32'd0);
    check("t2_disp_addr", 32'(mem_addr), 32'd9);
    step();
    disp_req = 1'b0; #1;
    check("t2_host_ack", 32'(host_ack), 32'd1);
    check("t2_host_addr", 32'(mem_addr), 32'd7);
    step();
    host_req = 1'b0;
    check("t2_dvalid", 32'(disp_valid), 32'd1);
    check("t2_ddata", 32'(disp_data), 32'h99);
    check("t2_hvalid_early", 32'(host_rvalid), 32'd0);
    step();
    check("t2_dvalid_pulse", 32'(disp_valid), 32'd0);
    check("t2_hvalid", 32'(host_rvalid), 32'd1);
    check("t2_hdata", 32'(host_rdata), 32'h77);
    step();

    // 4: range boundaries
    mem[2800] = 8'hAA; mem[3000] = 8'hBB;
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'd2799; host_wdata = 8'h5A; #1;
    check("t4_last_we", 32'(mem_we), 32'd1);
    check("t4_last_addr", 32'(mem_addr), 32'd2799);
    step();
    host_addr = 14'd2800; host_wdata = 8'h55; #1;
    check("t4_oor_wr_ack", 32'(host_ack), 32'd1);
    check("t4_oor_wr_we", 32'(mem_we), 32'd0);
    step();
    host_we = 1'b0; host_addr = 14'd3000; #1;
    check("t4_oor_rd_ack", 32'(host_ack), 32'd1);
    step();
    host_req = 1'b0; disp_req = 1'b1; disp_addr = 14'd3000;
    step();
    disp_req = 1'b0;
    check("t4_hvalid", 32'(host_rvalid), 32'd1);
    check("t4_hdata", 32'(host_rdata), 32'd0);
    step();
    check("t4_dvalid", 32'(disp_valid), 32'd1);
    check("t4_ddata", 32'(disp_data), 32'd0);
    check("t4_mem2799", 32'(mem[2799]), 32'h5A);
    check("t4_mem2800", 32'(mem[2800]), 32'hAA);

    // 3 + 6: full clear with display interleave and a second start mid-sweep
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    clr_start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 14'd10; host_wdata = 8'h33; #1;
    check("t3_host_with_start", 32'(host_ack), 32'd1);
    check("t3_busy_at_start", 32'(clr_busy), 32'd0);
    step();
    clr_start = 1'b0;
    busy_cnt = 0; last_busy = -1; disp_in_busy = 0; wr_cnt = 0; ack_idx = -1;
    for (int i = 0; i < 6000; i++) begin
      disp_req = ((i % 8) == 3); disp_addr = 14'd100; clr_start = (i == 500);
      host_req = 1'b1; host_we = 1'b0; host_addr = 14'd10; #1;
      if (i == 0) check("t3_busy_first", 32'(clr_busy), 32'd1);
      if (clr_busy) begin
        busy_cnt++;
        last_busy = i;
        if (disp_req) disp_in_busy++;
      end
      if (mem_we) wr_cnt++;
      if (host_ack) begin
        ack_idx = i;
        break;
      end
      step();
    end
    step();
    host_req = 1'b0; disp_req = 1'b0; clr_start = 1'b0;
    step();
    check("t3_hvalid", 32'(host_rvalid), 32'd1);
    check("t3_hdata", 32'(host_rdata), 32'h20);
    exp_ack = last_busy + 1 + ((((last_busy + 1) % 8) == 3) ? 1 : 0);
    check("t3_busy_cycles", 32'(busy_cnt), 32'(DEPTH + disp_in_busy));
    check("t3_clear_writes", 32'(wr_cnt), 32'(DEPTH));
    check("t3_ack_after_busy", 32'(ack_idx), 32'(exp_ack));
    bad_lo = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h20) bad_lo++;
    check("t3_bad_locations", 32'(bad_lo), 32'd0);
    check("t3_mem2800", 32'(mem[2800]), 32'hAA);
    check("t3_mem3000", 32'(mem[3000]), 32'hBB);
    check("t3_oor_writes", 32'(oor_writes), 32'd0);

    // 5: reset in the middle of a sweep with a display read in flight
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      #1;
      if (mem_we && (mem_addr == 14'd999)) begin
        found = 1;
        break;
      end
      step();
    end
    check("t5_found_999", 32'(found), 32'd1);
    step();
    disp_req = 1'b1; disp_addr = 14'd50; #1;
    check("t5_disp_steal", 32'(mem_we), 32'd0);
    step();
    disp_req = 1'b0; #1;
    check("t5_addr_1000", 32'(mem_addr), 32'd1000);
    resetn = 1'b0; #1;
    check("t5_rst_we", 32'(mem_we), 32'd0);
    check("t5_rst_busy", 32'(clr_busy), 32'd0);
    step();
    check("t5_no_dvalid", 32'(disp_valid), 32'd0);
    check("t5_ddata_zero", 32'(disp_data), 32'd0);
    check("t5_hdata_zero", 32'(host_rdata), 32'd0);
    step();
    resetn = 1'b1;
    step();
    check("t5_busy_after", 32'(clr_busy), 32'd0);
    check("t5_dvalid_after", 32'(disp_valid), 32'd0);
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 1000; i++) if (mem[i] !== 8'h20) bad_lo++;
    for (int i = 1000; i < DEPTH; i++) if (mem[i] !== 8'hFF) bad_hi++;
    check("t5_cleared_low", 32'(bad_lo), 32'd0);
    check("t5_kept_high", 32'(bad_hi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
